// File: rtl/vga_stream_timing.sv
// VGA timing generator (HS/VS/DE, x/y) that pulls one valid/ready stream word per displayed pixel.
// Latency: every output is registered, one cycle after the counter position or accepted word it describes.
// Backpressure: s_ready is combinational; words are only taken on active pixels once aligned to s_sof.
module vga_stream_timing #(
    parameter int              HDISP       = 800,
    parameter int              VDISP       = 480,
    parameter int              HFP         = 40,
    parameter int              HPULSE      = 48,
    parameter int              HBP         = 40,
    parameter int              VFP         = 13,
    parameter int              VPULSE      = 3,
    parameter int              VBP         = 29,
    parameter bit              HS_POL      = 1'b0,
    parameter bit              VS_POL      = 1'b0,
    parameter int              RGB_W       = 24,
    parameter logic [RGB_W-1:0] BLANK_COLOR = '0,
    localparam int             XW          = (HDISP > 1) ? $clog2(HDISP) : 1,
    localparam int             YW          = (VDISP > 1) ? $clog2(VDISP) : 1
) (
    input  logic             pixel_clk,
    input  logic             pixel_rst,
    input  logic [RGB_W-1:0] s_data,
    input  logic             s_sof,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             hs,
    output logic             vs,
    output logic             de,
    output logic [RGB_W-1:0] rgb,
    output logic [XW-1:0]    x,
    output logic [YW-1:0]    y,
    output logic             frame_start,
    output logic             underflow,
    output logic             sof_err,
    output logic [15:0]      err_cnt
);

    // Derived frame geometry: blanking (FP, PULSE, BP) precedes the active area.
    localparam int H      = HDISP + HFP + HPULSE + HBP;
    localparam int V      = VDISP + VFP + VPULSE + VBP;
    localparam int HBLANK = HFP + HPULSE + HBP;
    localparam int VBLANK = VFP + VPULSE + VBP;
    localparam int HCW    = (H > 1) ? $clog2(H) : 1;
    localparam int VCW    = (V > 1) ? $clog2(V) : 1;

    localparam logic [HCW-1:0] HC_LAST  = HCW'(H - 1);
    localparam logic [HCW-1:0] HC_BLANK = HCW'(HBLANK);
    localparam logic [HCW-1:0] HS_BEG   = HCW'(HFP);
    localparam logic [HCW-1:0] HS_END   = HCW'(HFP + HPULSE);
    localparam logic [VCW-1:0] VC_LAST  = VCW'(V - 1);
    localparam logic [VCW-1:0] VC_BLANK = VCW'(VBLANK);
    localparam logic [VCW-1:0] VS_BEG   = VCW'(VFP);
    localparam logic [VCW-1:0] VS_END   = VCW'(VFP + VPULSE);

    typedef enum logic {
        ST_SYNC = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [HCW-1:0]   hc_q, hc_d;
    logic [VCW-1:0]   vc_q, vc_d;

    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             de_q, de_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic             fs_q, fs_d;
    logic             uf_q, uf_d;
    logic             se_q, se_d;
    logic [15:0]      err_cnt_q, err_cnt_d;

    // Position decode for the current counter value.
    logic de_c;
    logic first_c;
    logic ready_c;
    logic take_c;

    assign de_c    = (hc_q >= HC_BLANK) && (vc_q >= VC_BLANK);
    assign first_c = (hc_q == HC_BLANK) && (vc_q == VC_BLANK);

    // Horizontal counter wraps at H-1; vertical counter advances on each line wrap.
    always_comb begin
        hc_d = hc_q + 1'b1;
        vc_d = vc_q;
        if (hc_q == HC_LAST) begin
            hc_d = '0;
            vc_d = (vc_q == VC_LAST) ? '0 : vc_q + 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge pixel_clk) begin
        if (pixel_rst) begin
            hc_q <= '0;
            vc_q <= '0;
        end else begin
            hc_q <= hc_d;
            vc_q <= vc_d;
        end
    end

    // FSM state register.
    always_ff @(posedge pixel_clk) begin
        if (pixel_rst) begin
            state_q <= ST_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: lock on an s_sof word at the first active pixel, drop lock on any stream error.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SYNC: begin
                if (s_valid && s_sof && first_c) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // s_sof must be present exactly on the first active pixel and nowhere else.
                if (de_c && (!s_valid || (s_sof != first_c))) begin
                    state_d = ST_SYNC;
                end
            end
            default: state_d = ST_SYNC;
        endcase
    end

    // FSM outputs: handshake, pixel take, and error events for the current position.
    always_comb begin
        ready_c = 1'b0;
        take_c  = 1'b0;
        uf_d    = 1'b0;
        se_d    = 1'b0;
        case (state_q)
            ST_SYNC: begin
                if (s_valid && !s_sof) begin
                    // Unaligned word: drain it without showing it.
                    ready_c = 1'b1;
                end else if (s_valid && s_sof && first_c) begin
                    ready_c = 1'b1;
                    take_c  = 1'b1;
                end
            end
            ST_RUN: begin
                if (de_c) begin
                    if (!s_valid) begin
                        uf_d = 1'b1;
                    end else if (s_sof == first_c) begin
                        ready_c = 1'b1;
                        take_c  = 1'b1;
                    end else if (first_c) begin
                        // First pixel without s_sof: discard the word as an unaligned one.
                        ready_c = 1'b1;
                        se_d    = 1'b1;
                    end else begin
                        // Early s_sof: leave the word in place to start the next frame.
                        se_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // No word may be consumed while the block is held in reset.
    assign s_ready = ready_c && !pixel_rst;

    // Next values of the registered video outputs.
    always_comb begin
        hs_d      = ((hc_q >= HS_BEG) && (hc_q < HS_END)) ? HS_POL : ~HS_POL;
        vs_d      = ((vc_q >= VS_BEG) && (vc_q < VS_END)) ? VS_POL : ~VS_POL;
        de_d      = de_c;
        rgb_d     = take_c ? s_data : BLANK_COLOR;
        x_d       = de_c ? XW'(hc_q - HC_BLANK) : '0;
        y_d       = de_c ? YW'(vc_q - VC_BLANK) : '0;
        fs_d      = (hc_q == '0) && (vc_q == '0);
        err_cnt_d = err_cnt_q;
        if ((uf_d || se_d) && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    // Output registers.
    always_ff @(posedge pixel_clk) begin
        if (pixel_rst) begin
            hs_q      <= ~HS_POL;
            vs_q      <= ~VS_POL;
            de_q      <= 1'b0;
            rgb_q     <= BLANK_COLOR;
            x_q       <= '0;
            y_q       <= '0;
            fs_q      <= 1'b0;
            uf_q      <= 1'b0;
            se_q      <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            de_q      <= de_d;
            rgb_q     <= rgb_d;
            x_q       <= x_d;
            y_q       <= y_d;
            fs_q      <= fs_d;
            uf_q      <= uf_d;
            se_q      <= se_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign hs          = hs_q;
    assign vs          = vs_q;
    assign de          = de_q;
    assign rgb         = rgb_q;
    assign x           = x_q;
    assign y           = y_q;
    assign frame_start = fs_q;
    assign underflow   = uf_q;
    assign sof_err     = se_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_vga_stream_timing.sv
// Bench for vga_stream_timing on a 4x2 display with unit porches/pulses (H=7, V=5, 35-cycle frame).
// Latency: outputs sampled 1 ns after each rising edge; s_ready sampled 1 ns after inputs change.
// Backpressure: stimulus is a per-cycle table whose expected s_ready values are precomputed.
module tb_vga_stream_timing;

    logic        pixel_clk;
    logic        pixel_rst;
    logic [23:0] s_data;
    logic        s_sof;
    logic        s_valid;
    logic        s_ready;
    logic        hs;
    logic        vs;
    logic        de;
    logic [23:0] rgb;
    logic [1:0]  x;
    logic [0:0]  y;
    logic        frame_start;
    logic        underflow;
    logic        sof_err;
    logic [15:0] err_cnt;

    vga_stream_timing #(
        .HDISP(4), .VDISP(2), .HFP(1), .HPULSE(1), .HBP(1),
        .VFP(1), .VPULSE(1), .VBP(1), .HS_POL(1'b0), .VS_POL(1'b0),
        .RGB_W(24), .BLANK_COLOR(24'h000000)
    ) dut (
        .pixel_clk(pixel_clk), .pixel_rst(pixel_rst),
        .s_data(s_data), .s_sof(s_sof), .s_valid(s_valid), .s_ready(s_ready),
        .hs(hs), .vs(vs), .de(de), .rgb(rgb), .x(x), .y(y),
        .frame_start(frame_start), .underflow(underflow), .sof_err(sof_err),
        .err_cnt(err_cnt)
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    typedef struct {
        bit          rst;
        bit          vld;
        bit          sof;
        logic [23:0] dat;
        bit          e_rdy;
        logic [23:0] e_rgb;
        bit          e_uf;
        bit          e_se;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[$];
    int   b_cnt;
    int   n_tests;
    int   n_fail;
    int   vidx;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (vector %0d): got %0h expected %0h", nm, vidx, act, exp);
        end
    endtask

    // Append one cycle; the expected error count follows the expected pulses.
    task automatic add(input bit rst, input bit vld, input bit sof, input int dat,
                       input bit rdy, input int rgbv, input bit uf, input bit se);
        vec_t v;
        if (rst) b_cnt = 0;
        else if (uf || se) b_cnt++;
        v.rst = rst; v.vld = vld; v.sof = sof; v.dat = 24'(dat);
        v.e_rdy = rdy; v.e_rgb = 24'(rgbv); v.e_uf = uf; v.e_se = se;
        v.e_cnt = 16'(b_cnt);
        tbl.push_back(v);
    endtask

    // One frame (positions 0..last_p) of a source presenting words w0+k for pixel k.
    // drop_k: pixel where valid drops; bad_k: pixel whose s_sof flag is inverted.
    task automatic frame(input bit pre3, input int drop_k, input int bad_k,
                         input int w0, input int last_p);
        bit err;
        int hc, vc, k;
        bit dep, sf;
        err = 1'b0;
        for (int p = 0; p <= last_p; p++) begin
            hc  = p % 7;
            vc  = p / 7;
            dep = (hc >= 3) && (vc >= 3);
            k   = dep ? (vc - 3) * 4 + hc - 3 : ((vc < 3) ? 0 : (vc - 3) * 4);
            sf  = (k == 0) ^ (k == bad_k);
            if (pre3 && p < 3)      add(0, 1, 0, 'hA0 + p, 1, 0, 0, 0);
            else if (err) begin
                if (bad_k > 0)      add(0, 1, 1, w0 + bad_k, 0, 0, 0, 0);
                else                add(0, 0, 0, 0, 0, 0, 0, 0);
            end
            else if (!dep)          add(0, 1, sf, w0 + k, 0, 0, 0, 0);
            else if (k == drop_k) begin
                add(0, 0, 0, 0, 0, 0, 1, 0);
                err = 1'b1;
            end
            else if (k == bad_k) begin
                add(0, 1, sf, w0 + k, (bad_k == 0), 0, 0, 1);
                err = 1'b1;
            end
            else                    add(0, 1, sf, w0 + k, 1, w0 + k, 0, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pos, hc, vc;
        bit dep, rst_v;
        int hs_low, vs_low, de_cnt, de_runs, run, max_run, fs_cnt, fs_first, fs_second, rgb_nz;
        vec_t v;

        n_tests = 0; n_fail = 0; vidx = -1; b_cnt = 0;

        // Reset state, with a non-sof word offered that must not be taken.
        pixel_rst = 1'b1; s_valid = 1'b1; s_sof = 1'b0; s_data = 24'h123456;
        repeat (2) @(posedge pixel_clk);
        #1;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_hs", hs, 1);
        chk("rst_vs", vs, 1);
        chk("rst_de", de, 0);
        chk("rst_rgb", rgb, 0);
        chk("rst_xy", {x, y}, 0);
        chk("rst_pulses", {frame_start, underflow, sof_err}, 0);
        chk("rst_err_cnt", err_cnt, 0);

        // Free-running timing over two frames with no stream.
        @(negedge pixel_clk);
        pixel_rst = 1'b0; s_valid = 1'b0;
        hs_low = 0; vs_low = 0; de_cnt = 0; de_runs = 0; run = 0; max_run = 0;
        fs_cnt = 0; fs_first = -1; fs_second = -1; rgb_nz = 0;
        for (int n = 0; n < 70; n++) begin
            @(posedge pixel_clk);
            #1;
            if (!hs) hs_low++;
            if (!vs) vs_low++;
            if (rgb != 0) rgb_nz++;
            if (de) begin
                de_cnt++;
                if (run == 0) de_runs++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (frame_start) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = n;
                else if (fs_second < 0) fs_second = n;
            end
        end
        chk("tim_hs_low", hs_low, 10);
        chk("tim_vs_low", vs_low, 14);
        chk("tim_de_cnt", de_cnt, 16);
        chk("tim_de_runs", de_runs, 4);
        chk("tim_de_maxrun", max_run, 4);
        chk("tim_fs_cnt", fs_cnt, 2);
        chk("tim_fs_first", fs_first, 0);
        chk("tim_fs_period", fs_second - fs_first, 35);
        chk("tim_rgb_blank", rgb_nz, 0);

        // Streaming with pre-sync discard, then repeated aligned frames.
        add(1, 0, 0, 0, 0, 0, 0, 0);
        frame(1, -1, -1, 1, 34);
        frame(0, -1, -1, 1, 34);
        frame(0, -1, -1, 1, 34);
        // Underflow on the 3rd pixel, then recovery.
        add(1, 0, 0, 0, 0, 0, 0, 0);
        frame(0, -1, -1, 1, 34);
        frame(0, 2, -1, 1, 34);
        frame(0, -1, -1, 1, 34);
        // Early s_sof on the 5th word, then missing s_sof on a first pixel.
        add(1, 0, 0, 0, 0, 0, 0, 0);
        frame(0, -1, -1, 1, 34);
        frame(0, -1, 4, 1, 34);
        frame(0, -1, -1, 5, 34);
        frame(0, -1, 0, 1, 34);
        frame(0, -1, -1, 1, 34);
        // Reset in the middle of a frame at hc=4, vc=3 after an error was counted.
        add(1, 0, 0, 0, 0, 0, 0, 0);
        frame(0, -1, -1, 1, 34);
        frame(0, 2, -1, 1, 34);
        frame(0, -1, -1, 1, 24);
        add(1, 1, 0, 2, 0, 0, 0, 0);
        frame(0, -1, -1, 1, 34);

        pos = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            vidx = i;
            @(negedge pixel_clk);
            pixel_rst = v.rst; s_valid = v.vld; s_sof = v.sof; s_data = v.dat;
            #1;
            chk("s_ready", s_ready, v.e_rdy);
            @(posedge pixel_clk);
            #1;
            rst_v = v.rst;
            hc  = pos % 7;
            vc  = pos / 7;
            dep = !rst_v && (hc >= 3) && (vc >= 3);
            chk("rgb", rgb, v.e_rgb);
            chk("underflow", underflow, v.e_uf);
            chk("sof_err", sof_err, v.e_se);
            chk("err_cnt", err_cnt, v.e_cnt);
            chk("hs", hs, rst_v ? 1 : (hc != 1));
            chk("vs", vs, rst_v ? 1 : (vc != 1));
            chk("de", de, dep);
            chk("x", x, dep ? hc - 3 : 0);
            chk("y", y, dep ? vc - 3 : 0);
            chk("frame_start", frame_start, !rst_v && (pos == 0));
            pos = rst_v ? 0 : (pos + 1) % 35;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
